// File: rtl/num_storage_pkg.sv
// Shared defaults and clear-FSM state type for the multi-bank number storage RAM.
package num_storage_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 2048;
  localparam int DEF_NUM_BANKS  = 4;

  typedef enum logic {
    CLR_IDLE,
    CLR_SWEEP
  } clr_state_t;

endpackage

// File: rtl/num_ram_bank.sv
// One storage bank: dual-port memory, background clear sweep and the bank-local
// write/read guards (busy, entering sweep, address range).
module num_ram_bank
  import num_storage_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ok,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ok,
  output logic [DATA_WIDTH-1:0] rd_q
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  clr_state_t            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign busy  = (state == CLR_SWEEP);
  assign wr_ok = wr_en && !busy && !clear && ({1'b0, wr_addr} < DEPTH_L);
  assign rd_ok = !busy && ({1'b0, rd_addr} < DEPTH_L);

  // A request arriving mid-sweep restarts from word 0 rather than being queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLR_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (clear) begin
            state <= CLR_SWEEP;
            ptr   <= '0;
          end
        end
        CLR_SWEEP: begin
          if (clear) begin
            ptr <= '0;
          end else if (ptr == LAST) begin
            state <= CLR_IDLE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= CLR_IDLE;
      endcase
    end
  end

  // Sweep and user writes share one port; user writes are never accepted while sweeping.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en && rd_ok) begin
      rd_q <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/num_storage_bank_ram.sv
// Multi-bank number storage RAM: bank decode, drop flag, registered read mux.
// Optional write-first forwarding is enabled by defining NUM_STORAGE_BYPASS_EN.
module num_storage_bank_ram
  import num_storage_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_all,
  input  logic [NUM_BANKS-1:0]  clear_req,
  output logic [NUM_BANKS-1:0]  clear_busy,
  input  logic                  wr_en,
  input  logic [BANK_W-1:0]     wr_bank,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_drop,
  input  logic                  rd_en,
  input  logic [BANK_W-1:0]     rd_bank,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  logic [NUM_BANKS-1:0]  wr_sel, rd_sel, wr_ok, rd_ok, rd_sel_q;
  logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_data;
  logic                  wr_accept, rd_hit, rd_zero_q;

  // Bank indices beyond NUM_BANKS match no bank, so they fall out as drops / zero reads.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_sel[b] = (wr_bank == BANK_W'(b));
      rd_sel[b] = (rd_bank == BANK_W'(b));
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    num_ram_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear_all | clear_req[g]),
      .busy   (clear_busy[g]),
      .wr_en  (wr_en & wr_sel[g]),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .wr_ok  (wr_ok[g]),
      .rd_en  (rd_en & rd_sel[g]),
      .rd_addr(rd_addr),
      .rd_ok  (rd_ok[g]),
      .rd_q   (bank_q[g])
    );
  end

  assign wr_accept = |wr_ok;
  assign rd_hit    = |(rd_sel & rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_zero_q <= 1'b1;
      rd_sel_q  <= '0;
    end else begin
      wr_drop  <= wr_en & ~wr_accept;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_zero_q <= ~rd_hit;
        rd_sel_q  <= rd_sel;
      end
    end
  end

  always_comb begin
    bank_data = '0;
    if (!rd_zero_q) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rd_sel_q[b]) bank_data = bank_q[b];
      end
    end
  end

`ifdef NUM_STORAGE_BYPASS_EN
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  // Only an accepted write forwards; a dropped write leaves the read untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else if (rd_en) begin
      byp_q      <= wr_accept && rd_hit && (wr_bank == rd_bank) && (wr_addr == rd_addr);
      byp_data_q <= wr_data;
    end
  end

  assign rd_data = byp_q ? byp_data_q : bank_data;
`else
  assign rd_data = bank_data;
`endif

endmodule

// File: tb/tb_num_storage_bank_ram.sv
// Directed self-checking bench for num_storage_bank_ram (default build and,
// when NUM_STORAGE_BYPASS_EN is defined, the write-first build).
module tb_num_storage_bank_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_all;
  logic [3:0]  clear_req;
  logic [3:0]  clear_busy;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_drop;
  logic        rd_en;
  logic [1:0]  rd_bank;
  logic [10:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  logic        o_clear_all;
  logic [2:0]  o_clear_req;
  logic [2:0]  o_clear_busy;
  logic        o_wr_en;
  logic [1:0]  o_wr_bank;
  logic [9:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_wr_drop;
  logic        o_rd_en;
  logic [1:0]  o_rd_bank;
  logic [9:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_valid;

  int checks = 0;
  int fails  = 0;
  int cnt;

`ifdef NUM_STORAGE_BYPASS_EN
  localparam logic [31:0] EXP_CONFLICT = 32'hBB;
`else
  localparam logic [31:0] EXP_CONFLICT = 32'hAA;
`endif

  always #5 clk = ~clk;

  num_storage_bank_ram dut (
    .clk(clk), .rst_n(rst_n), .clear_all(clear_all), .clear_req(clear_req),
    .clear_busy(clear_busy), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_drop(wr_drop), .rd_en(rd_en), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  num_storage_bank_ram #(.DATA_WIDTH(32), .DEPTH(1000), .NUM_BANKS(3)) dut_oor (
    .clk(clk), .rst_n(rst_n), .clear_all(o_clear_all), .clear_req(o_clear_req),
    .clear_busy(o_clear_busy), .wr_en(o_wr_en), .wr_bank(o_wr_bank), .wr_addr(o_wr_addr),
    .wr_data(o_wr_data), .wr_drop(o_wr_drop), .rd_en(o_rd_en), .rd_bank(o_rd_bank),
    .rd_addr(o_rd_addr), .rd_data(o_rd_data), .rd_valid(o_rd_valid)
  );

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic writeWord(input string tag, input logic [1:0] b, input logic [10:0] a,
                           input logic [31:0] d, input logic exp_drop);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    applyStimulus();
    wr_en = 1'b0;
    checkOutput(tag, {31'b0, wr_drop}, {31'b0, exp_drop});
  endtask

  task automatic readCheck(input string tag, input logic [1:0] b, input logic [10:0] a,
                           input logic [31:0] exp_data);
    rd_en = 1'b1; rd_bank = b; rd_addr = a;
    applyStimulus();
    rd_en = 1'b0;
    checkOutput({tag, " valid"}, {31'b0, rd_valid}, 32'd1);
    checkOutput({tag, " data"}, rd_data, exp_data);
  endtask

  task automatic oWriteWord(input string tag, input logic [1:0] b, input logic [9:0] a,
                            input logic [31:0] d, input logic exp_drop);
    o_wr_en = 1'b1; o_wr_bank = b; o_wr_addr = a; o_wr_data = d;
    applyStimulus();
    o_wr_en = 1'b0;
    checkOutput(tag, {31'b0, o_wr_drop}, {31'b0, exp_drop});
  endtask

  task automatic oReadCheck(input string tag, input logic [1:0] b, input logic [9:0] a,
                            input logic [31:0] exp_data);
    o_rd_en = 1'b1; o_rd_bank = b; o_rd_addr = a;
    applyStimulus();
    o_rd_en = 1'b0;
    checkOutput({tag, " valid"}, {31'b0, o_rd_valid}, 32'd1);
    checkOutput({tag, " data"}, o_rd_data, exp_data);
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 4000; i++) begin
      if (clear_busy == 4'b0) break;
      applyStimulus();
    end
    checkOutput(tag, {28'b0, clear_busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_all = 1'b0; clear_req = '0; wr_en = 1'b0; wr_bank = '0; wr_addr = '0;
    wr_data = '0; rd_en = 1'b0; rd_bank = '0; rd_addr = '0;
    o_clear_all = 1'b0; o_clear_req = '0; o_wr_en = 1'b0; o_wr_bank = '0;
    o_wr_addr = '0; o_wr_data = '0; o_rd_en = 1'b0; o_rd_bank = '0; o_rd_addr = '0;
    $display("[TB] start");

    // Reset state
    repeat (3) applyStimulus();
    checkOutput("reset clear_busy", {28'b0, clear_busy}, 32'd0);
    checkOutput("reset rd_valid", {31'b0, rd_valid}, 32'd0);
    checkOutput("reset rd_data", rd_data, 32'd0);
    checkOutput("reset wr_drop", {31'b0, wr_drop}, 32'd0);
    rst_n = 1'b1;
    applyStimulus();

    // Full clear in both instances; main bank sweep length is DEPTH cycles
    clear_all = 1'b1; o_clear_all = 1'b1;
    applyStimulus();
    clear_all = 1'b0; o_clear_all = 1'b0;
    checkOutput("clear_all busy rise", {28'b0, clear_busy}, 32'hF);
    cnt = 1;
    for (int i = 0; i < 5000; i++) begin
      applyStimulus();
      if (clear_busy != 4'hF) break;
      cnt++;
    end
    checkOutput("clear_all busy length", cnt, 32'd2048);
    checkOutput("clear_all busy fall", {28'b0, clear_busy}, 32'd0);
    checkOutput("oor clear done", {29'b0, o_clear_busy}, 32'd0);

    readCheck("rd b2a5 after clear", 2'd2, 11'd5, 32'd0);
    applyStimulus();
    checkOutput("rd_valid single cycle", {31'b0, rd_valid}, 32'd0);

    // Write / read back, including a read the cycle right after the write
    writeWord("wr b1a2047 accepted", 2'd1, 11'd2047, 32'hDEADBEEF, 1'b0);
    writeWord("wr b3a0 accepted", 2'd3, 11'd0, 32'h12345678, 1'b0);
    readCheck("rd b3a0", 2'd3, 11'd0, 32'h12345678);
    readCheck("rd b1a2047", 2'd1, 11'd2047, 32'hDEADBEEF);
    applyStimulus();
    checkOutput("rd_data holds", rd_data, 32'hDEADBEEF);
    readCheck("rd b0a2047 untouched", 2'd0, 11'd2047, 32'd0);
    readCheck("rd b3a2047 untouched", 2'd3, 11'd2047, 32'd0);

    // Single-bank clear on bank 2
    clear_req = 4'b0100;
    applyStimulus();
    clear_req = 4'b0000;
    checkOutput("bank2 only busy", {28'b0, clear_busy}, 32'h4);
    repeat (10) applyStimulus();
    writeWord("wr bank2 mid-sweep drop", 2'd2, 11'd3, 32'h11111111, 1'b1);
    writeWord("wr bank0 during sweep", 2'd0, 11'd3, 32'h55, 1'b0);
    readCheck("rd bank2 sweeping", 2'd2, 11'd3, 32'd0);
    readCheck("rd bank1 during sweep", 2'd1, 11'd2047, 32'hDEADBEEF);
    waitIdle("bank2 sweep end");
    readCheck("rd b0a3 after", 2'd0, 11'd3, 32'h55);
    readCheck("rd b2a3 after", 2'd2, 11'd3, 32'd0);

    // Restart bank 0 at sweep cycle 1000; write on the entering edge is dropped
    clear_req = 4'b0001;
    wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 11'd3; wr_data = 32'h1;
    applyStimulus();
    clear_req = 4'b0000; wr_en = 1'b0;
    checkOutput("wr on clear edge drop", {31'b0, wr_drop}, 32'd1);
    checkOutput("bank0 busy rise", {28'b0, clear_busy}, 32'h1);
    cnt = 1;
    for (int i = 0; i < 6000; i++) begin
      clear_req = (cnt == 1000) ? 4'b0001 : 4'b0000;
      applyStimulus();
      if (clear_busy[0] == 1'b0) break;
      cnt++;
    end
    clear_req = 4'b0000;
    checkOutput("restart busy length", cnt, 32'd3048);

    // Same-cycle read/write conflict on bank 0 addr 7
    writeWord("wr b0a7 AA", 2'd0, 11'd7, 32'hAA, 1'b0);
    wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 11'd7; wr_data = 32'hBB;
    rd_en = 1'b1; rd_bank = 2'd0; rd_addr = 11'd7;
    applyStimulus();
    wr_en = 1'b0; rd_en = 1'b0;
    checkOutput("conflict rd_data", rd_data, EXP_CONFLICT);
    checkOutput("conflict wr_drop", {31'b0, wr_drop}, 32'd0);
    readCheck("rd after conflict", 2'd0, 11'd7, 32'hBB);

    // Dropped write alongside a read: read sees the stored word in both builds
    clear_req = 4'b0001;
    wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 11'd7; wr_data = 32'hCC;
    rd_en = 1'b1; rd_bank = 2'd0; rd_addr = 11'd7;
    applyStimulus();
    clear_req = 4'b0000; wr_en = 1'b0; rd_en = 1'b0;
    checkOutput("dropped conflict wr_drop", {31'b0, wr_drop}, 32'd1);
    checkOutput("dropped conflict rd_data", rd_data, 32'hBB);
    waitIdle("bank0 second sweep end");
    readCheck("rd b0a7 after sweep", 2'd0, 11'd7, 32'd0);

    // Out-of-range bank and address on the 3-bank, 1000-word instance
    oWriteWord("oor wr b2a999 accepted", 2'd2, 10'd999, 32'h99, 1'b0);
    oWriteWord("oor wr bank3 drop", 2'd3, 10'd5, 32'h77, 1'b1);
    oWriteWord("oor wr addr1000 drop", 2'd0, 10'd1000, 32'h66, 1'b1);
    oWriteWord("oor wr addr1023 drop", 2'd1, 10'd1023, 32'h44, 1'b1);
    oReadCheck("oor rd b2a999", 2'd2, 10'd999, 32'h99);
    oReadCheck("oor rd bank3", 2'd3, 10'd5, 32'd0);
    oReadCheck("oor rd addr1000", 2'd0, 10'd1000, 32'd0);
    oReadCheck("oor rd b0a5 unchanged", 2'd0, 10'd5, 32'd0);
    oReadCheck("oor rd b1a999 unchanged", 2'd1, 10'd999, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/num_storage_bank_ram.md
# num_storage_bank_ram

Multi-bank successor to the single-bank number storage RAM in the ASCII number separator path. It holds converted integers in `NUM_BANKS` independent dual-port banks, for example one per matrix operand. Each bank has its own background clear sweep with a busy flag. Reads are registered and carry a valid strobe, and writes aimed at a bank that is clearing are dropped and flagged.

## Interface
- `DATA_WIDTH`, 32, width of one stored word
- `DEPTH`, 2048, words per bank; need not be a power of two; minimum 2
- `ADDR_WIDTH`, `$clog2(DEPTH)`, word address width
- `NUM_BANKS`, 4, bank count; minimum 1
- `BANK_W`, `NUM_BANKS>1 ? $clog2(NUM_BANKS) : 1`, bank index width

Ports (reset rst_n, asynchronous, active-low; clock clk):
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `clear_all`  in  1  pulse; starts a clear sweep in every bank
- `clear_req`  in  NUM_BANKS  per-bank clear start, one bit per bank
- `clear_busy`  out  NUM_BANKS  bank sweep in progress
- `wr_en`  in  1  write strobe
- `wr_bank`  in  BANK_W  target bank
- `wr_addr`  in  ADDR_WIDTH  target word
- `wr_data`  in  DATA_WIDTH  write data
- `wr_drop`  out  1  registered pulse; the previous-cycle write was discarded
- `rd_en`  in  1  read strobe
- `rd_bank`  in  BANK_W  source bank
- `rd_addr`  in  ADDR_WIDTH  source word
- `rd_data`  out  DATA_WIDTH  registered read data
- `rd_valid`  out  1  `rd_data` is valid this cycle

## Operation
- **Per-bank clear FSM.** States are IDLE and SWEEP.
  - IDLE→SWEEP when `clear_all | clear_req[b]` is high. The sweep pointer loads 0.
  - In SWEEP, the bank writes 0 to `mem[ptr]` each cycle and increments the pointer.
  - At `ptr==DEPTH-1`, that final word is written, then the bank returns to IDLE.
  - A new request while in SWEEP restarts the sweep: the pointer reloads 0 and the bank stays in SWEEP.
- **Write rules.**
  - A write is discarded and `wr_drop` pulses next cycle when any of these holds:
    - the target bank is in SWEEP, or enters SWEEP on that same edge;
    - `wr_bank >= NUM_BANKS`;
    - `wr_addr >= DEPTH`.
  - Otherwise `mem[wr_bank][wr_addr] <= wr_data`.
- **Read rules.**
  - `rd_en` always produces `rd_valid` one cycle later.
  - `rd_data` is 0 when any of these holds in the request cycle:
    - the bank is in SWEEP;
    - the bank index is out of range;
    - the address is out of range.
  - Otherwise `rd_data` is the stored word.
  - When `rd_en` is low, `rd_data` holds its last value.
- **Simultaneity.** Read and write to the same bank and address in the same cycle are read-first by default; see Configuration. Reads and writes to different banks are fully independent.
- **Memory at reset.** Memory is not initialised by reset; contents are undefined until that bank has been swept once.

## Timing
- Reset values:
  - `clear_busy=0`
  - `rd_data=0`
  - `rd_valid=0`
  - `wr_drop=0`
  - all FSMs in IDLE
- **Reset mid-sweep.** The sweep is aborted and `clear_busy` drops immediately. Contents of the partially swept bank are undefined.
- **Read latency.** 1 cycle, from `rd_en` sampled to `rd_valid`/`rd_data`. Full throughput: one read per cycle, no backpressure.
- **Write latency.** A written word is readable by a read issued the next cycle.
- **`clear_busy[b]` timing.**
  - Rises on the edge that samples the request.
  - Stays high for exactly DEPTH cycles when not restarted.
  - Falls on the edge after the word at `DEPTH-1` is written.
- **`wr_drop` timing.** Rises the cycle after the offending write and stays high for 1 cycle per dropped write.

## Configuration
- Macro: `NUM_STORAGE_BYPASS_EN`.
- **Defined:** a same-cycle read and accepted write to the same bank and address return `wr_data` (write-first forwarding). A read in the same cycle as a dropped write is unaffected, and still returns 0 when the bank is sweeping.
- **Undefined:** the same case returns the old stored word (read-first). No forwarding mux is present.

## Structure
- Package `num_storage_pkg`:
  - default `DATA_WIDTH`, `DEPTH`, `NUM_BANKS` constants;
  - typedef `clr_state_t` enum `{CLR_IDLE, CLR_SWEEP}`.
- Sub-module `num_ram_bank`: one bank's memory, clear FSM, `busy` output and port guards. The top instantiates it `NUM_BANKS` times via generate.
- The top holds bank decode, range checks, `wr_drop` generation, read mux, output registers and the optional bypass.

## Test plan
- **Reset and clear.** Reset, then `clear_all`.
  - `clear_busy=4'hF` for exactly 2048 cycles, then 0.
  - A read of bank 2 addr 5 returns 0 with `rd_valid` one cycle after `rd_en`.
- **Write/read back.** Write `0xDEADBEEF` to bank 1 addr 2047 and `0x12345678` to bank 3 addr 0. Reading them back returns those values at 1-cycle latency, and other banks are unchanged.
- **Single-bank clear.** Pulse `clear_req=4'b0100`.
  - Only `clear_busy[2]` rises.
  - A write to bank 2 mid-sweep gives `wr_drop=1` next cycle.
  - A write to bank 0 in the same window succeeds.
- **Restart mid-sweep.** Re-assert `clear_req[0]` at sweep cycle 1000. `clear_busy[0]` stays high for a total of 1000+2048 cycles.
- **Out of range.** With `NUM_BANKS=3`, write to bank 3, and separately write to an address at or beyond `DEPTH=1000`. Each gives `wr_drop=1` and no memory change. Reads from those locations return 0 with `rd_valid=1`.
- **Same-cycle conflict.** Bank 0 addr 7 holds `0xAA`. Read and write `0xBB` to bank 0 addr 7 in the same cycle.
  - Returns `0xBB` with `NUM_STORAGE_BYPASS_EN` defined, `0xAA` without.
  - The next read returns `0xBB` in both builds.
